complex_mul_arbiter: RTL and testbench

COMPLEX_MUL_ARBITER -- requirements
Module: complex_mul_arbiter

---
 rtl/complex_mul_arbiter.sv | 161 ++++++++++++++++
 tb/tb_complex_mul_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mul_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one complex multiplier,
// with at most one transaction in flight and results broadcast to all requesters.
module complex_mul_arbiter #(
    parameter int n    = 32,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*n-1:0]    req_ar,
    input  logic [NREQ*n-1:0]    req_ac,
    input  logic [NREQ*n-1:0]    req_br,
    input  logic [NREQ*n-1:0]    req_bc,

    output logic [NREQ-1:0]      resp_val,
    input  logic [NREQ-1:0]      resp_rdy,
    output logic [n-1:0]         resp_cr,
    output logic [n-1:0]         resp_cc,

    output logic                 mul_recv_val,
    input  logic                 mul_recv_rdy,
    output logic [n-1:0]         mul_ar,
    output logic [n-1:0]         mul_ac,
    output logic [n-1:0]         mul_br,
    output logic [n-1:0]         mul_bc,

    input  logic                 mul_send_val,
    output logic                 mul_send_rdy,
    input  logic [n-1:0]         mul_cr,
    input  logic [n-1:0]         mul_cc
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [n-1:0]    ar_q, ar_d, ac_q, ac_d, br_q, br_d, bc_q, bc_d;
    logic [n-1:0]    cr_q, cr_d, cc_q, cc_d;

    logic [PW-1:0]   grant_idx;
    logic [PW:0]     cand;

    // Walk downward so the candidate closest to ptr is the last one written.
    always_comb begin
        grant_idx = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (PW + 1)'(k);
            if (cand >= (PW + 1)'(NREQ)) begin
                cand = cand - (PW + 1)'(NREQ);
            end
            if (req_val[cand[PW-1:0]]) begin
                grant_idx = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state variable gets a default first, so no path can infer a latch.
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        ar_d         = ar_q;
        ac_d         = ac_q;
        br_d         = br_q;
        bc_d         = bc_q;
        cr_d         = cr_q;
        cc_d         = cc_q;
        req_rdy      = '0;
        resp_val     = '0;
        mul_recv_val = 1'b0;
        mul_send_rdy = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req_val) begin
                    req_rdy[grant_idx] = 1'b1;
                    idx_d   = grant_idx;
                    ar_d    = req_ar[grant_idx*n +: n];
                    ac_d    = req_ac[grant_idx*n +: n];
                    br_d    = req_br[grant_idx*n +: n];
                    bc_d    = req_bc[grant_idx*n +: n];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_recv_val = 1'b1;
                if (mul_recv_rdy) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                mul_send_rdy = 1'b1;
                if (mul_send_val) begin
                    cr_d    = mul_cr;
                    cc_d    = mul_cc;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_val[idx_q] = 1'b1;
                if (resp_rdy[idx_q]) begin
                    ptr_d   = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake outputs must read zero while reset is held, before the state register clears.
        if (reset) begin
            req_rdy      = '0;
            resp_val     = '0;
            mul_recv_val = 1'b0;
            mul_send_rdy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the captured operands and result are reset too, so nothing stale is visible after an abort.
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            ar_q    <= '0;
            ac_q    <= '0;
            br_q    <= '0;
            bc_q    <= '0;
            cr_q    <= '0;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            ar_q    <= ar_d;
            ac_q    <= ac_d;
            br_q    <= br_d;
            bc_q    <= bc_d;
            cr_q    <= cr_d;
            cc_q    <= cc_d;
        end
    end

    assign mul_ar  = ar_q;
    assign mul_ac  = ac_q;
    assign mul_br  = br_q;
    assign mul_bc  = bc_q;
    assign resp_cr = cr_q;
    assign resp_cc = cc_q;

endmodule

// File: tb/tb_complex_mul_arbiter.sv
// Directed bench for complex_mul_arbiter: the bench plays the Q16.16 complex
// multiplier and every requester, checking grants, operands and responses.
module tb_complex_mul_arbiter;

    localparam int N  = 32;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_val, req_rdy, resp_val, resp_rdy;
    logic [NR*N-1:0]   req_ar, req_ac, req_br, req_bc;
    logic [N-1:0]      resp_cr, resp_cc;
    logic              mul_recv_val, mul_recv_rdy, mul_send_val, mul_send_rdy;
    logic [N-1:0]      mul_ar, mul_ac, mul_br, mul_bc, mul_cr, mul_cc;

    int total = 0;
    int bad   = 0;

    complex_mul_arbiter #(.n(N), .NREQ(NR)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_ar       (req_ar),
        .req_ac       (req_ac),
        .req_br       (req_br),
        .req_bc       (req_bc),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_cr      (resp_cr),
        .resp_cc      (resp_cc),
        .mul_recv_val (mul_recv_val),
        .mul_recv_rdy (mul_recv_rdy),
        .mul_ar       (mul_ar),
        .mul_ac       (mul_ac),
        .mul_br       (mul_br),
        .mul_bc       (mul_bc),
        .mul_send_val (mul_send_val),
        .mul_send_rdy (mul_send_rdy),
        .mul_cr       (mul_cr),
        .mul_cc       (mul_cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] rv;
        int            grant;
        logic [N-1:0]  ar, ac, br, bc;
        int            lat, recv_stall, resp_stall;
        logic [N-1:0]  exp_cr, exp_cc;
    } txn_t;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Q16.16 complex product as the external multiplier would return it.
    function automatic logic [N-1:0] q_re(input logic [N-1:0] ar, ac, br, bc);
        longint p;
        p = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ac)) * longint'($signed(bc));
        return N'(p >>> 16);
    endfunction

    function automatic logic [N-1:0] q_im(input logic [N-1:0] ar, ac, br, bc);
        longint p;
        p = longint'($signed(ar)) * longint'($signed(bc)) + longint'($signed(ac)) * longint'($signed(br));
        return N'(p >>> 16);
    endfunction

    task automatic run_txn(input txn_t t);
        logic [NR-1:0] oh;
        oh = NR'(1) << t.grant;
        for (int i = 0; i < NR; i++) begin
            req_ar[i*N +: N] = (i == t.grant) ? t.ar : 32'hDEAD_0000 | i;
            req_ac[i*N +: N] = (i == t.grant) ? t.ac : 32'hBEEF_0000 | i;
            req_br[i*N +: N] = (i == t.grant) ? t.br : 32'hCAFE_0000 | i;
            req_bc[i*N +: N] = (i == t.grant) ? t.bc : 32'hF00D_0000 | i;
        end
        req_val = t.rv;
        #1;
        check("grant", req_rdy, oh);
        step();
        req_ar = '1; req_ac = '1; req_br = '1; req_bc = '1;
        #1;
        check("issue_no_rdy", req_rdy, '0);
        mul_recv_rdy = 1'b0;
        for (int s = 0; s <= t.recv_stall; s++) begin
            check("issue_val", mul_recv_val, 1'b1);
            check("issue_send_rdy", mul_send_rdy, 1'b0);
            check("op_ar", mul_ar, t.ar);
            check("op_ac", mul_ac, t.ac);
            check("op_br", mul_br, t.br);
            check("op_bc", mul_bc, t.bc);
            if (s < t.recv_stall) begin
                mul_send_val = 1'b1;
                mul_cr = 32'h5555_5555;
                mul_cc = 32'hAAAA_AAAA;
                step();
                mul_send_val = 1'b0;
            end
        end
        mul_recv_rdy = 1'b1;
        step();
        mul_recv_rdy = 1'b0;
        for (int w = 1; w < t.lat; w++) begin
            check("wait_rdy", mul_send_rdy, 1'b1);
            check("wait_no_resp", resp_val, '0);
            step();
        end
        check("wait_rdy", mul_send_rdy, 1'b1);
        check("wait_no_issue", mul_recv_val, 1'b0);
        mul_cr = q_re(t.ar, t.ac, t.br, t.bc);
        mul_cc = q_im(t.ar, t.ac, t.br, t.bc);
        mul_send_val = 1'b1;
        step();
        mul_send_val = 1'b0;
        mul_cr = 32'h1234_5678;
        mul_cc = 32'h8765_4321;
        for (int r = 0; r <= t.resp_stall; r++) begin
            resp_rdy = (r < t.resp_stall) ? ~oh : '0;
            mul_send_val = (r < t.resp_stall);
            req_val = '1;
            #1;
            check("resp_val", resp_val, oh);
            check("resp_cr", resp_cr, t.exp_cr);
            check("resp_cc", resp_cc, t.exp_cc);
            check("resp_no_req_rdy", req_rdy, '0);
            check("resp_send_rdy", mul_send_rdy, 1'b0);
            if (r < t.resp_stall) step();
        end
        mul_send_val = 1'b0;
        resp_rdy = '1;
        #1;
        check("resp_done_no_accept", req_rdy, '0);
        step();
        resp_rdy = '0;
        req_val  = '0;
        #1;
        check("back_idle", resp_val, '0);
    endtask

    txn_t tbl[11];
    txn_t extra;

    initial begin
        tbl[0]  = '{4'b0001, 0, 32'h0002_0000, 32'h0001_0000, 32'h0003_0000, 32'hFFFF_0000, 5, 0, 0, 32'h0007_0000, 32'h0001_0000};
        tbl[1]  = '{4'b1111, 1, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1, 0, 0, 32'hFFFB_0000, 32'h000A_0000};
        tbl[2]  = '{4'b1111, 2, 32'hFFFE_0000, 32'h0000_0000, 32'h0005_0000, 32'h0001_0000, 2, 0, 0, 32'hFFF6_0000, 32'hFFFE_0000};
        tbl[3]  = '{4'b1111, 3, 32'h0000_8000, 32'h0000_8000, 32'h0002_0000, 32'h0002_0000, 1, 0, 0, 32'h0000_0000, 32'h0002_0000};
        tbl[4]  = '{4'b1111, 0, 32'h0004_0000, 32'hFFFD_0000, 32'h0001_0000, 32'h0002_0000, 3, 0, 0, 32'h000A_0000, 32'h0005_0000};
        tbl[5]  = '{4'b1000, 3, 32'h0002_0000, 32'h0001_0000, 32'h0003_0000, 32'hFFFF_0000, 1, 0, 0, 32'h0007_0000, 32'h0001_0000};
        tbl[6]  = '{4'b0100, 2, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1, 0, 0, 32'hFFFB_0000, 32'h000A_0000};
        tbl[7]  = '{4'b0001, 0, 32'hFFFE_0000, 32'h0000_0000, 32'h0005_0000, 32'h0001_0000, 2, 0, 0, 32'hFFF6_0000, 32'hFFFE_0000};
        tbl[8]  = '{4'b1010, 1, 32'h0000_8000, 32'h0000_8000, 32'h0002_0000, 32'h0002_0000, 1, 0, 0, 32'h0000_0000, 32'h0002_0000};
        tbl[9]  = '{4'b1001, 3, 32'h0004_0000, 32'hFFFD_0000, 32'h0001_0000, 32'h0002_0000, 1, 0, 0, 32'h000A_0000, 32'h0005_0000};
        tbl[10] = '{4'b0110, 1, 32'h0002_0000, 32'h0001_0000, 32'h0003_0000, 32'hFFFF_0000, 4, 4, 3, 32'h0007_0000, 32'h0001_0000};

        reset = 1'b1; req_val = '1; resp_rdy = '0;
        req_ar = '1; req_ac = '1; req_br = '1; req_bc = '1;
        mul_recv_rdy = 1'b1; mul_send_val = 1'b1;
        mul_cr = 32'h1111_1111; mul_cc = 32'h2222_2222;
        step();
        step();
        check("rst_req_rdy", req_rdy, '0);
        check("rst_resp_val", resp_val, '0);
        check("rst_recv_val", mul_recv_val, 1'b0);
        check("rst_send_rdy", mul_send_rdy, 1'b0);
        check("rst_resp_cr", resp_cr, '0);
        check("rst_resp_cc", resp_cc, '0);
        check("rst_mul_ar", mul_ar, '0);
        reset = 1'b0; req_val = '0; mul_send_val = 1'b0; mul_recv_rdy = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i]);
        end

        // Spurious result in IDLE must leave the held result alone.
        mul_send_val = 1'b1;
        mul_cr = 32'h1234_5678;
        mul_cc = 32'h0BAD_0BAD;
        step();
        mul_send_val = 1'b0;
        check("idle_spur_cr", resp_cr, 32'h0007_0000);
        check("idle_spur_cc", resp_cc, 32'h0001_0000);
        check("idle_spur_resp", resp_val, '0);
        check("idle_spur_issue", mul_recv_val, 1'b0);

        // Abort a transaction while it waits on the multiplier.
        req_val = 4'b0100;
        #1;
        check("pre_abort_grant", req_rdy, 4'b0100);
        step();
        req_val = '0;
        mul_recv_rdy = 1'b1;
        step();
        mul_recv_rdy = 1'b0;
        check("pre_abort_wait", mul_send_rdy, 1'b1);
        reset = 1'b1;
        req_val = '1;
        #1;
        check("abort_req_rdy", req_rdy, '0);
        check("abort_send_rdy", mul_send_rdy, 1'b0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_grant", req_rdy, 4'b0001);
        check("post_rst_resp", resp_val, '0);
        check("post_rst_send_rdy", mul_send_rdy, 1'b0);
        check("post_rst_cr", resp_cr, '0);
        check("post_rst_ar", mul_ar, '0);
        req_val = '0;
        mul_send_val = 1'b1;
        mul_cr = 32'h7777_7777;
        mul_cc = 32'h6666_6666;
        step();
        mul_send_val = 1'b0;
        check("late_result_resp", resp_val, '0);
        check("late_result_cr", resp_cr, '0);
        check("late_result_issue", mul_recv_val, 1'b0);

        extra = '{4'b0010, 1, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1, 0, 0, 32'hFFFB_0000, 32'h000A_0000};
        run_txn(extra);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
